// File: rtl/bp_vc_pkg.sv
// bp_vc_pkg: shared types and constants for the victim cache controller
package bp_vc_pkg;

    localparam int vc_block_width  = 512;
    localparam int vc_tag_width    = 34;
    localparam int vc_stat_width   = 2;
    localparam int vc_num_entries  = 4;
    localparam int vc_stat_invalid = 0;

    typedef enum logic {
        e_vc_ready,
        e_vc_flush
    } vc_state_e;

    typedef struct packed {
        logic [vc_block_width-1:0] data;
        logic [vc_tag_width-1:0]   tag;
        logic [vc_stat_width-1:0]  stat;
    } vc_line_s;

endpackage

// File: rtl/bp_vc_rr_arb2.sv
// bp_vc_rr_arb2: two-requester round-robin arbiter; bit 0 wins a tie while the pointer is 0
module bp_vc_rr_arb2 (
    input  logic       clk_i,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_r;

    // a lone requester is granted directly; a tie is settled by the pointer
    always_comb gnt = (&req) ? (ptr_r ? 2'b10 : 2'b01) : req;

    // after a tie the pointer moves toward the requester that lost
    always_ff @(posedge clk_i or posedge reset)
        if (reset)
            ptr_r <= 1'b0;
        else if (&req)
            ptr_r <= ~ptr_r;

endmodule

// File: rtl/bp_vc_ctrl.sv
// bp_vc_ctrl: arbitrates inserts and lookups into the victim cache array, buffers dirty push-outs, sequences flushes
module bp_vc_ctrl
    import bp_vc_pkg::*;
#(
    parameter int block_width = vc_block_width,
    parameter int tag_width   = vc_tag_width,
    parameter int stat_width  = vc_stat_width,
    parameter int num_entries = vc_num_entries
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   ins_v_i,
    output logic                   ins_ready_o,
    input  logic [block_width-1:0] ins_data_i,
    input  logic [tag_width-1:0]   ins_tag_i,
    input  logic [stat_width-1:0]  ins_stat_i,
    input  logic                   lkup_v_i,
    output logic                   lkup_ready_o,
    input  logic [tag_width-1:0]   lkup_tag_i,
    input  logic                   lkup_remove_i,
    output logic                   resp_v_o,
    input  logic                   resp_ready_i,
    output logic                   resp_hit_o,
    output logic [block_width-1:0] resp_data_o,
    output logic [stat_width-1:0]  resp_stat_o,
    output logic                   wb_v_o,
    input  logic                   wb_ready_i,
    output logic [block_width-1:0] wb_data_o,
    output logic [tag_width-1:0]   wb_tag_o,
    output logic [stat_width-1:0]  wb_stat_o,
    input  logic                   flush_v_i,
    output logic                   flush_ready_o,
    output logic                   flush_done_o,
    output logic                   vc_evict_in_o,
    output logic [block_width-1:0] vc_evict_data_o,
    output logic [tag_width-1:0]   vc_evict_tag_o,
    output logic [stat_width-1:0]  vc_evict_stat_o,
    output logic [tag_width-1:0]   vc_tag_r_o,
    output logic                   vc_remove_o,
    input  logic                   vc_hit_i,
    input  logic [block_width-1:0] vc_data_i,
    input  logic [stat_width-1:0]  vc_stat_i,
    input  logic                   vc_evict_i,
    input  logic [block_width-1:0] vc_data_evict_i,
    input  logic [tag_width-1:0]   vc_tag_evict_i,
    input  logic [stat_width-1:0]  vc_stat_evict_i
);

    localparam int cnt_width = $clog2(num_entries + 1);

    vc_state_e            state_r;
    logic [cnt_width-1:0] cnt_r;
    logic [tag_width-1:0] tag_r;
    logic [1:0]           gnt;
    logic                 is_ready;
    logic                 resp_free;
    logic                 wb_free;
    logic                 hit;
    logic                 flush_go;
    logic                 flush_push;
    logic                 flush_end;
    logic                 capture;

    assign is_ready  = state_r == e_vc_ready;
    assign resp_free = !resp_v_o | resp_ready_i;
    assign wb_free   = !wb_v_o | wb_ready_i;

    // bit 0 is the lookup side so the pointer starts out favouring lookups
    bp_vc_rr_arb2 arb (
        .clk_i (clk_i),
        .reset (reset),
        .req   ({is_ready & ins_v_i & wb_free, is_ready & lkup_v_i & resp_free}),
        .gnt   (gnt)
    );

    assign lkup_ready_o  = gnt[0];
    assign ins_ready_o   = gnt[1];
    assign flush_ready_o = is_ready & ~|gnt;
    assign flush_go      = flush_v_i & flush_ready_o;

    assign flush_push = !is_ready & (cnt_r != cnt_width'(num_entries)) & wb_free;
    assign flush_end  = !is_ready & (cnt_r == cnt_width'(num_entries)) & !wb_v_o;

    // an array hit only counts when the matched entry is valid
    assign hit         = vc_hit_i & (vc_stat_i != stat_width'(vc_stat_invalid));
    assign vc_tag_r_o  = gnt[0] ? lkup_tag_i : tag_r;
    assign vc_remove_o = gnt[0] & hit & lkup_remove_i;

    // flush pushes a null line through the array to shove every entry out
    assign vc_evict_in_o   = gnt[1] | flush_push;
    assign vc_evict_data_o = gnt[1] ? ins_data_i : '0;
    assign vc_evict_tag_o  = gnt[1] ? ins_tag_i  : '0;
    assign vc_evict_stat_o = gnt[1] ? ins_stat_i : '0;
    assign capture         = vc_evict_in_o & vc_evict_i;

    // flush sequencer: push num_entries null lines, then wait for the last writeback to drain
    always_ff @(posedge clk_i or posedge reset)
        if (reset) begin
            state_r      <= e_vc_ready;
            cnt_r        <= '0;
            flush_done_o <= 1'b0;
        end else begin
            flush_done_o <= flush_end;
            if (flush_go) begin
                state_r <= e_vc_flush;
                cnt_r   <= '0;
            end else if (flush_end)
                state_r <= e_vc_ready;
            else if (flush_push)
                cnt_r <= cnt_r + 1'b1;
        end

    // one-entry response slot, also remembers the last tag presented to the array
    always_ff @(posedge clk_i or posedge reset)
        if (reset) begin
            resp_v_o    <= 1'b0;
            resp_hit_o  <= 1'b0;
            resp_data_o <= '0;
            resp_stat_o <= '0;
            tag_r       <= '0;
        end else if (gnt[0]) begin
            resp_v_o    <= 1'b1;
            resp_hit_o  <= hit;
            resp_data_o <= hit ? vc_data_i : '0;
            resp_stat_o <= hit ? vc_stat_i : '0;
            tag_r       <= lkup_tag_i;
        end else if (resp_ready_i)
            resp_v_o <= 1'b0;

    // one-entry writeback slot: pushes only happen when it is free, so a capture never overwrites
    always_ff @(posedge clk_i or posedge reset)
        if (reset) begin
            wb_v_o    <= 1'b0;
            wb_data_o <= '0;
            wb_tag_o  <= '0;
            wb_stat_o <= '0;
        end else if (capture) begin
            wb_v_o    <= 1'b1;
            wb_data_o <= vc_data_evict_i;
            wb_tag_o  <= vc_tag_evict_i;
            wb_stat_o <= vc_stat_evict_i;
        end else if (wb_ready_i)
            wb_v_o <= 1'b0;

endmodule

// File: tb/tb_bp_vc_ctrl.sv
// tb_bp_vc_ctrl: scoreboard bench for bp_vc_ctrl with a shift-register array stub and a queue reference model
module tb_bp_vc_ctrl;
    import bp_vc_pkg::*;

    localparam int bw = vc_block_width;
    localparam int tw = vc_tag_width;
    localparam int sw = vc_stat_width;
    localparam int ne = vc_num_entries;

    typedef struct packed {
        logic          hit;
        logic [bw-1:0] data;
        logic [sw-1:0] stat;
    } resp_s;

    logic          clk_i = 1'b0;
    logic          reset = 1'b0;
    logic          ins_v_i = 1'b0, ins_ready_o;
    logic [bw-1:0] ins_data_i = '0;
    logic [tw-1:0] ins_tag_i = '0;
    logic [sw-1:0] ins_stat_i = '0;
    logic          lkup_v_i = 1'b0, lkup_ready_o;
    logic [tw-1:0] lkup_tag_i = '0;
    logic          lkup_remove_i = 1'b0;
    logic          resp_v_o, resp_ready_i = 1'b1, resp_hit_o;
    logic [bw-1:0] resp_data_o;
    logic [sw-1:0] resp_stat_o;
    logic          wb_v_o, wb_ready_i = 1'b1;
    logic [bw-1:0] wb_data_o;
    logic [tw-1:0] wb_tag_o;
    logic [sw-1:0] wb_stat_o;
    logic          flush_v_i = 1'b0, flush_ready_o, flush_done_o;
    logic          vc_evict_in_o;
    logic [bw-1:0] vc_evict_data_o;
    logic [tw-1:0] vc_evict_tag_o;
    logic [sw-1:0] vc_evict_stat_o;
    logic [tw-1:0] vc_tag_r_o;
    logic          vc_remove_o;
    logic          vc_hit_i;
    logic [bw-1:0] vc_data_i;
    logic [sw-1:0] vc_stat_i;
    logic          vc_evict_i;
    logic [bw-1:0] vc_data_evict_i;
    logic [tw-1:0] vc_tag_evict_i;
    logic [sw-1:0] vc_stat_evict_i;

    always #5 clk_i = ~clk_i;

    bp_vc_ctrl dut (
        .clk_i(clk_i), .reset(reset),
        .ins_v_i(ins_v_i), .ins_ready_o(ins_ready_o), .ins_data_i(ins_data_i),
        .ins_tag_i(ins_tag_i), .ins_stat_i(ins_stat_i),
        .lkup_v_i(lkup_v_i), .lkup_ready_o(lkup_ready_o), .lkup_tag_i(lkup_tag_i),
        .lkup_remove_i(lkup_remove_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_hit_o(resp_hit_o),
        .resp_data_o(resp_data_o), .resp_stat_o(resp_stat_o),
        .wb_v_o(wb_v_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_tag_o(wb_tag_o), .wb_stat_o(wb_stat_o),
        .flush_v_i(flush_v_i), .flush_ready_o(flush_ready_o), .flush_done_o(flush_done_o),
        .vc_evict_in_o(vc_evict_in_o), .vc_evict_data_o(vc_evict_data_o),
        .vc_evict_tag_o(vc_evict_tag_o), .vc_evict_stat_o(vc_evict_stat_o),
        .vc_tag_r_o(vc_tag_r_o), .vc_remove_o(vc_remove_o),
        .vc_hit_i(vc_hit_i), .vc_data_i(vc_data_i), .vc_stat_i(vc_stat_i),
        .vc_evict_i(vc_evict_i), .vc_data_evict_i(vc_data_evict_i),
        .vc_tag_evict_i(vc_tag_evict_i), .vc_stat_evict_i(vc_stat_evict_i)
    );

    // array stub: slot 0 newest, first tag match wins, a push-out is dirty when stat bit 0 is set
    vc_line_s arr [ne];
    logic     stub_hit;
    int       hit_idx;

    always_comb begin
        stub_hit = 1'b0;
        hit_idx  = 0;
        for (int i = ne - 1; i >= 0; i--)
            if (arr[i].tag == vc_tag_r_o) begin
                stub_hit = 1'b1;
                hit_idx  = i;
            end
    end

    assign vc_hit_i        = stub_hit;
    assign vc_data_i       = stub_hit ? arr[hit_idx].data : {16{32'hdeadbeef}};
    assign vc_stat_i       = stub_hit ? arr[hit_idx].stat : 2'b11;
    assign vc_evict_i      = vc_evict_in_o & arr[ne-1].stat[0];
    assign vc_data_evict_i = arr[ne-1].data;
    assign vc_tag_evict_i  = arr[ne-1].tag;
    assign vc_stat_evict_i = arr[ne-1].stat;

    always @(posedge clk_i or posedge reset)
        if (reset) begin
            for (int i = 0; i < ne; i++) arr[i] <= '0;
        end else if (vc_evict_in_o) begin
            arr[0] <= {vc_evict_data_o, vc_evict_tag_o, vc_evict_stat_o};
            for (int i = 1; i < ne; i++) arr[i] <= arr[i-1];
        end else if (vc_remove_o)
            arr[hit_idx].stat <= '0;

    int       tests = 0, fails = 0;
    int       null_pushes = 0, wb_xfers = 0, done_cnt = 0, remove_cnt = 0;
    resp_s    resp_exp [$];
    vc_line_s wb_exp [$];
    vc_line_s ref_q [$];
    resp_s    exp_r, got_r;
    vc_line_s exp_wb;

    task automatic chk(input string name, input logic [bw-1:0] act, input logic [bw-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [bw-1:0] rand_data();
        logic [bw-1:0] d;
        for (int i = 0; i < bw / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // reference: the cache is a fixed-length queue, newest first; pushing drops the oldest
    function automatic void model_push(input vc_line_s l);
        vc_line_s old;
        ref_q.push_front(l);
        old = ref_q.pop_back();
        if (old.stat[0]) wb_exp.push_back(old);
    endfunction

    function automatic resp_s model_lookup(input logic [tw-1:0] t, input logic rm);
        resp_s    r = '0;
        vc_line_s e;
        for (int i = 0; i < ne; i++)
            if (ref_q[i].tag == t) begin
                e = ref_q[i];
                if (e.stat != 0) begin
                    r = '{1'b1, e.data, e.stat};
                    if (rm) begin
                        e.stat = '0;
                        ref_q[i] = e;
                    end
                end
                return r;
            end
        return r;
    endfunction

    // stimulus side: record accepted requests into the model and queue expectations
    always @(negedge clk_i)
        if (!reset) begin
            if (lkup_v_i && lkup_ready_o) begin
                exp_r = model_lookup(lkup_tag_i, lkup_remove_i);
                resp_exp.push_back(exp_r);
                chk("lkup_tag_r", vc_tag_r_o, lkup_tag_i);
                chk("lkup_remove", vc_remove_o, exp_r.hit & lkup_remove_i);
            end else
                chk("remove_idle", vc_remove_o, 0);
            if (ins_v_i && ins_ready_o) begin
                chk("ins_push", vc_evict_in_o, 1);
                model_push({ins_data_i, ins_tag_i, ins_stat_i});
            end
            if (flush_v_i && flush_ready_o)
                for (int i = 0; i < ne; i++) model_push('0);
        end

    // monitor side: pop and compare whatever the DUT hands out
    always @(negedge clk_i)
        if (!reset) begin
            if (resp_v_o && resp_ready_i) begin
                if (resp_exp.size() == 0)
                    chk("resp_unexpected", resp_v_o, 0);
                else begin
                    got_r = resp_exp.pop_front();
                    chk("resp_hit", resp_hit_o, got_r.hit);
                    chk("resp_data", resp_data_o, got_r.data);
                    chk("resp_stat", resp_stat_o, got_r.stat);
                end
            end
            if (wb_v_o && wb_ready_i) begin
                wb_xfers++;
                if (wb_exp.size() == 0)
                    chk("wb_unexpected", wb_v_o, 0);
                else begin
                    exp_wb = wb_exp.pop_front();
                    chk("wb_tag", wb_tag_o, exp_wb.tag);
                    chk("wb_data", wb_data_o, exp_wb.data);
                    chk("wb_stat", wb_stat_o, exp_wb.stat);
                end
            end
            if (vc_evict_in_o && !ins_ready_o) begin
                null_pushes++;
                chk("null_push_tag", {vc_evict_tag_o, vc_evict_stat_o}, 0);
                chk("null_push_data", vc_evict_data_o, 0);
            end
            if (vc_remove_o) remove_cnt++;
            if (flush_done_o) done_cnt++;
            chk("one_grant", ins_ready_o & lkup_ready_o, 0);
            chk("push_needs_wb_slot", vc_evict_in_o & wb_v_o & !wb_ready_i, 0);
            chk("ins_vs_remove", vc_evict_in_o & vc_remove_o, 0);
        end

    task automatic reset_dut();
        reset = 1'b1;
        ins_v_i = 1'b0; lkup_v_i = 1'b0; flush_v_i = 1'b0;
        resp_exp.delete(); wb_exp.delete(); ref_q.delete();
        for (int i = 0; i < ne; i++) ref_q.push_back('0);
        repeat (2) @(posedge clk_i);
        #1 reset = 1'b0;
    endtask

    task automatic do_ins(input logic [tw-1:0] t, input logic [sw-1:0] s, input logic [bw-1:0] d);
        int n = 0;
        ins_v_i = 1'b1; ins_tag_i = t; ins_stat_i = s; ins_data_i = d;
        #3;
        while (!ins_ready_o && n < 50) begin @(posedge clk_i); #4; n++; end
        chk("ins_accept_in_time", n < 50, 1);
        @(posedge clk_i); #1;
        ins_v_i = 1'b0;
    endtask

    task automatic do_lkup(input logic [tw-1:0] t, input logic rm);
        int n = 0;
        lkup_v_i = 1'b1; lkup_tag_i = t; lkup_remove_i = rm;
        #3;
        while (!lkup_ready_o && n < 50) begin @(posedge clk_i); #4; n++; end
        chk("lkup_accept_in_time", n < 50, 1);
        @(posedge clk_i); #1;
        lkup_v_i = 1'b0;
    endtask

    task automatic do_flush();
        int n = 0;
        flush_v_i = 1'b1;
        #3;
        while (!flush_ready_o && n < 50) begin @(posedge clk_i); #4; n++; end
        chk("flush_accept_in_time", n < 50, 1);
        @(posedge clk_i); #1;
        flush_v_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        #3;
        while (!flush_done_o && n < 60) begin @(posedge clk_i); #4; n++; end
        chk("flush_done_in_time", n < 60, 1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [bw-1:0] d;
        int p0, w0, d0, n, lat3, lat4;
        #1 reset = 1'b1;
        #1;
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_wb_v", wb_v_o, 0);
        chk("rst_done", flush_done_o, 0);
        chk("rst_evict_in", vc_evict_in_o, 0);
        chk("rst_remove", vc_remove_o, 0);
        chk("rst_tag_r", vc_tag_r_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
        chk("rst_wb_tag", wb_tag_o, 0);
        chk("rst_flush_ready", flush_ready_o, 1);
        reset_dut();

        for (int k = 0; k < 6; k++) begin
            ins_v_i = 1'b1; ins_tag_i = tw'(32'h60 + k); ins_stat_i = 2'd2; ins_data_i = rand_data();
            lkup_v_i = 1'b1; lkup_tag_i = 'h55; lkup_remove_i = 1'b0;
            #3;
            chk("rr_lkup", lkup_ready_o, (k % 2) == 0);
            chk("rr_ins", ins_ready_o, (k % 2) == 1);
            @(posedge clk_i); #1;
        end
        ins_v_i = 1'b0; lkup_v_i = 1'b0;
        repeat (3) @(posedge clk_i); #1;

        d = rand_data();
        p0 = remove_cnt;
        do_ins('h10, 2'd1, d);
        do_lkup('h10, 1'b1);
        chk("hit_resp_v", resp_v_o, 1);
        chk("hit_resp_hit", resp_hit_o, 1);
        chk("hit_resp_data", resp_data_o, d);
        do_lkup('h10, 1'b0);
        chk("miss_resp_hit", resp_hit_o, 0);
        chk("miss_resp_stat", resp_stat_o, 0);
        repeat (3) @(posedge clk_i); #1;
        chk("remove_pulses", remove_cnt - p0, 1);

        reset_dut();
        wb_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) do_ins(tw'(32'h20 + k), 2'd1, rand_data());
        chk("fill_no_wb", wb_v_o, 0);
        do_ins('h24, 2'd1, rand_data());
        chk("fifth_wb_v", wb_v_o, 1);
        chk("fifth_wb_tag", wb_tag_o, 'h20);
        ins_v_i = 1'b1; ins_tag_i = 'h25; ins_stat_i = 2'd1; ins_data_i = rand_data();
        for (int k = 0; k < 3; k++) begin
            #3 chk("sixth_blocked", ins_ready_o, 0);
            @(posedge clk_i); #1;
        end
        wb_ready_i = 1'b1;
        #3 chk("sixth_released", ins_ready_o, 1);
        @(posedge clk_i); #1;
        wb_ready_i = 1'b0; ins_v_i = 1'b0;
        chk("sixth_wb_tag", wb_tag_o, 'h21);
        wb_ready_i = 1'b1;
        repeat (3) @(posedge clk_i); #1;

        do_ins('h30, 2'd1, rand_data());
        do_ins('h31, 2'd2, rand_data());
        do_ins('h32, 2'd1, rand_data());
        do_ins('h33, 2'd2, rand_data());
        repeat (4) @(posedge clk_i); #1;
        p0 = null_pushes; w0 = wb_xfers; d0 = done_cnt;
        do_flush();
        wait_done(n);
        lat3 = n;
        repeat (3) @(posedge clk_i); #1;
        chk("flush_pushes", null_pushes - p0, 4);
        chk("flush_wb_xfers", wb_xfers - w0, 2);
        chk("flush_done_once", done_cnt - d0, 1);
        for (int k = 0; k < 4; k++) begin
            do_lkup(tw'(32'h30 + k), 1'b0);
            chk("post_flush_miss", resp_hit_o, 0);
        end

        for (int k = 0; k < 4; k++) do_ins(tw'(32'h40 + k), 2'd1, rand_data());
        repeat (4) @(posedge clk_i); #1;
        wb_ready_i = 1'b0;
        p0 = null_pushes; d0 = done_cnt;
        do_flush();
        @(posedge clk_i); #1;
        chk("stall_first_push", null_pushes - p0, 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            chk("stall_frozen", null_pushes - p0, 1);
        end
        @(posedge clk_i); #1;
        wb_ready_i = 1'b1;
        wait_done(n);
        lat4 = 6 + n;
        chk("stall_delays_done", lat4 >= lat3 + 5, 1);
        repeat (3) @(posedge clk_i); #1;
        chk("stall_pushes", null_pushes - p0, 4);
        chk("stall_done_once", done_cnt - d0, 1);

        reset_dut();
        p0 = null_pushes; d0 = done_cnt;
        do_flush();
        n = 0;
        while (null_pushes - p0 < 2 && n < 20) begin @(posedge clk_i); #1; n++; end
        chk("mid_flush_two_pushes", null_pushes - p0, 2);
        reset = 1'b1;
        #1;
        chk("async_resp_v", resp_v_o, 0);
        chk("async_wb_v", wb_v_o, 0);
        chk("async_done", flush_done_o, 0);
        chk("async_evict_in", vc_evict_in_o, 0);
        chk("async_remove", vc_remove_o, 0);
        chk("async_state_ready", flush_ready_o, 1);
        reset_dut();
        repeat (8) @(posedge clk_i); #1;
        chk("aborted_no_done", done_cnt - d0, 0);
        chk("aborted_no_push", vc_evict_in_o, 0);

        repeat (400) begin
            ins_v_i       = 1'($urandom_range(0, 1));
            ins_tag_i     = tw'($urandom_range(1, 6));
            ins_stat_i    = sw'($urandom_range(0, 3));
            ins_data_i    = rand_data();
            lkup_v_i      = 1'($urandom_range(0, 1));
            lkup_tag_i    = tw'($urandom_range(0, 6));
            lkup_remove_i = 1'($urandom_range(0, 1));
            resp_ready_i  = $urandom_range(0, 3) != 0;
            wb_ready_i    = $urandom_range(0, 3) != 0;
            flush_v_i     = $urandom_range(0, 29) == 0;
            @(posedge clk_i); #1;
        end
        ins_v_i = 1'b0; lkup_v_i = 1'b0; flush_v_i = 1'b0;
        resp_ready_i = 1'b1; wb_ready_i = 1'b1;
        repeat (30) @(posedge clk_i); #1;
        chk("resp_drained", resp_exp.size(), 0);
        chk("wb_drained", wb_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
